// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - address map, STATUS layout and region decode for dmem_mmio
package mmio_pkg;

    localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_0000;
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0004;
    localparam logic [31:0] CYCLES_ADDR = 32'hFFFF_0008;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_TX,
        REG_STATUS,
        REG_CYCLES,
        REG_NONE
    } region_t;

    // Takes the word address (byte address bits 31:2); byte lanes never matter.
    function automatic region_t decode_region(input logic [29:0] waddr);
        if (waddr[29:26] == 4'h0)             return REG_RAM;
        if (waddr == TXDATA_ADDR[31:2])       return REG_TX;
        if (waddr == STATUS_ADDR[31:2])       return REG_STATUS;
        if (waddr == CYCLES_ADDR[31:2])       return REG_CYCLES;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// rtl/dmem_mmio_if.sv - core load/store bus plus TX byte drain stream
interface dmem_mmio_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output memwrite, addr, writedata, tx_ready,
        input  readdata, tx_valid, tx_data
    );

    modport slave (
        input  memwrite, addr, writedata, tx_ready,
        output readdata, tx_valid, tx_data
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push while full is accepted only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only entries between the pointers are ever visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data-memory stage: word RAM, TX byte FIFO and cycle counter behind one bus
module dmem_mmio
    import mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    dmem_mmio_if.slave bus
);
    localparam int RAW = $clog2(RAM_WORDS);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    region_t         region;
    logic [RAW-1:0]  ram_idx;
    logic [31:0]     ram [RAM_WORDS];
    logic [31:0]     cycles;
    logic            ovf;
    logic [31:0]     status;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            unused_byte_lanes;

    assign unused_byte_lanes = &{1'b0, bus.addr[1:0]};

    assign region  = decode_region(bus.addr[31:2]);
    assign ram_idx = bus.addr[RAW+1:2];

    assign push = bus.memwrite && (region == REG_TX);
    assign pop  = bus.tx_valid && bus.tx_ready;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (bus.writedata[7:0]),
        .pop   (pop),
        .dout  (bus.tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.tx_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        if (bus.memwrite && (region == REG_RAM)) ram[ram_idx] <= bus.writedata;
    end

    // An overflow in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            ovf <= 1'b1;
        end else if (bus.memwrite && (region == REG_STATUS) && bus.writedata[ST_OVF]) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycles <= '0;
        end else if (bus.memwrite && (region == REG_CYCLES)) begin
            cycles <= bus.writedata;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    always_comb begin
        status                      = '0;
        status[ST_FULL]             = fifo_full;
        status[ST_EMPTY]            = fifo_empty;
        status[ST_OVF]              = ovf;
        status[ST_CNT_LSB +: 8]     = 8'(fifo_count);
    end

    always_comb begin
        bus.readdata = '0;
        case (region)
            REG_RAM:    bus.readdata = ram[ram_idx];
            REG_STATUS: bus.readdata = status;
            REG_CYCLES: bus.readdata = cycles;
            default:    bus.readdata = '0;
        endcase
    end

endmodule
